// File: rtl/cnn_pkg.sv
// Shared types and slice helpers for the CNN layer sequencer.
package cnn_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_RELU,
        S_POOL,
        S_CAPTURE,
        S_FINISH
    } seq_state_t;

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic logic is_stage(input seq_state_t s);
        return (s == S_CONV) || (s == S_RELU) || (s == S_POOL);
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_stage_timer.sv
// Per-stage watchdog: down-counter loaded on stage entry, expires in the stage's TIMEOUT-th cycle.
module stage_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = CNT_W'(TIMEOUT - 1);
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // TIMEOUT of 0 means the stages may take as long as they need.
    assign expired_o = (TIMEOUT != 0) && en_i && (count_q == '0);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences conv -> relu -> maxpool once per filter and collects each pooled map.
//  state   | meaning
//  IDLE    | waiting for start; stages held in reset
//  LOAD    | latch filter for current channel into conv_filter
//  CONV    | conv2d running
//  RELU    | conv2d + relu running
//  POOL    | conv2d + relu + max_pool2d running
//  CAPTURE | store pooled map for channel, stages back in reset
//  FINISH  | one-cycle done pulse, then IDLE
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_FILTERS  = 4,
    parameter int KERNEL_WIDTH = 3,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POOLED_WIDTH = 3,
    parameter int TIMEOUT      = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    input  logic [NUM_FILTERS*KERNEL_WIDTH*KERNEL_WIDTH*WEIGHT_WIDTH-1:0] filter_bank,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*WEIGHT_WIDTH-1:0]             conv_filter,
    output logic conv_reset,
    output logic relu_reset,
    output logic pool_reset,
    input  logic conv_done,
    input  logic relu_done,
    input  logic pool_done,
    input  logic [POOLED_WIDTH*POOLED_WIDTH*WORD_W-1:0]             pooled_in,
    output logic [NUM_FILTERS*POOLED_WIDTH*POOLED_WIDTH*WORD_W-1:0] out_maps,
    output logic [$clog2(NUM_FILTERS):0]                            channel_idx
);
    localparam int FILT_W = KERNEL_WIDTH * KERNEL_WIDTH * WEIGHT_WIDTH;
    localparam int MAP_W  = POOLED_WIDTH * POOLED_WIDTH * WORD_W;
    localparam int CH_W   = $clog2(NUM_FILTERS) + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_FILTERS - 1);

    seq_state_t        state_q, state_d;
    logic              first_q;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              error_q, error_d;
    logic [FILT_W-1:0] conv_filter_q, conv_filter_d;
    logic [MAP_W-1:0]  maps_q [NUM_FILTERS];
    logic [FILT_W-1:0] filt_arr [NUM_FILTERS];
    logic              stage_done, done_seen, expired;

    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_slice
        assign filt_arr[g] = filter_bank[slice_lsb(g, FILT_W) +: FILT_W];
        assign out_maps[slice_lsb(g, MAP_W) +: MAP_W] = maps_q[g];
    end

    stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (state_d != state_q),
        .en_i      (is_stage(state_q)),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            first_q       <= 1'b0;
            chan_q        <= '0;
            error_q       <= 1'b0;
            conv_filter_q <= '0;
            for (int c = 0; c < NUM_FILTERS; c++) maps_q[c] <= '0;
        end else begin
            state_q       <= state_d;
            first_q       <= (state_d != state_q);
            chan_q        <= chan_d;
            error_q       <= error_d;
            conv_filter_q <= conv_filter_d;
            for (int c = 0; c < NUM_FILTERS; c++) begin
                if (state_q == S_IDLE && start) begin
                    maps_q[c] <= '0;
                end else if (state_q == S_CAPTURE && int'(chan_q) == c) begin
                    maps_q[c] <= pooled_in;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        error_d       = error_q;
        conv_filter_d = conv_filter_q;
        case (state_q)
            S_CONV:  stage_done = conv_done;
            S_RELU:  stage_done = relu_done;
            S_POOL:  stage_done = pool_done;
            default: stage_done = 1'b0;
        endcase
        // The done level left over from the previous stage/channel is not trusted on entry.
        done_seen = stage_done && !first_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    chan_d  = '0;
                    error_d = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_CONV;
                for (int c = 0; c < NUM_FILTERS; c++) begin
                    if (int'(chan_q) == c) conv_filter_d = filt_arr[c];
                end
            end
            S_CONV, S_RELU, S_POOL: begin
                if (done_seen) begin
                    state_d = (state_q == S_CONV) ? S_RELU :
                              (state_q == S_RELU) ? S_POOL : S_CAPTURE;
                end else if (expired) begin
                    state_d = S_FINISH;
                    error_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (chan_q == LAST_CH) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_LOAD;
                    chan_d  = chan_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_FINISH);
        error       = error_q;
        channel_idx = chan_q;
        conv_filter = conv_filter_q;
        // Upstream stages stay released so their outputs remain valid downstream.
        conv_reset  = !is_stage(state_q);
        relu_reset  = !(state_q == S_RELU || state_q == S_POOL);
        pool_reset  = (state_q != S_POOL);
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: 2 filters, stage models with 2-cycle latency, TIMEOUT=8.
module tb_cnn_layer_sequencer;
    localparam int NF     = 2;
    localparam int KW     = 3;
    localparam int WW     = 8;
    localparam int PW     = 3;
    localparam int TO     = 8;
    localparam int LAT    = 2;
    localparam int FILT_W = KW * KW * WW;
    localparam int MAP_W  = PW * PW * 32;
    localparam int CW     = NF * MAP_W;
    localparam int CH_W   = $clog2(NF) + 1;
    // per channel: LOAD + 3 stages of (LAT+1) + CAPTURE; FINISH seen on the edge after the last channel
    localparam int EXP_LAT       = NF * (1 + 3 * (LAT + 1) + 1);
    // conv done already high: CONV takes 2 cycles
    localparam int EXP_LAT_STALE = NF * (1 + 2 + 2 * (LAT + 1) + 1);

    typedef logic [CW-1:0] cw_t;

    localparam logic [FILT_W-1:0] F0   = {9{8'hA5}};
    localparam logic [FILT_W-1:0] F1   = {9{8'hB6}};
    localparam logic [MAP_W-1:0]  PAT0 = {9{32'h1234_5670}};
    localparam logic [MAP_W-1:0]  PAT1 = {9{32'h89AB_CDEF}};

    logic clk;
    logic reset;
    logic start;
    logic busy, done, error;
    logic [NF*FILT_W-1:0] filter_bank;
    logic [FILT_W-1:0]    conv_filter;
    logic conv_reset, relu_reset, pool_reset;
    logic conv_done, relu_done, pool_done;
    logic [MAP_W-1:0]     pooled_in = '0;
    logic [CW-1:0]        out_maps;
    logic [CH_W-1:0]      channel_idx;

    logic conv_force, relu_stall;
    logic [3:0] c_cnt, r_cnt, p_cnt;

    int n_chk, n_pass;
    int done_count = 0;
    int conv_seen = 0;
    int pool_seen = 0;
    int conv_only_len = 0;
    logic [FILT_W-1:0] filt_seen [2];
    logic [CH_W-1:0]   chidx_seen [2];
    logic busy_p = 1'b0;
    logic conv_p = 1'b1;
    logic pool_p = 1'b1;

    cnn_layer_sequencer #(
        .NUM_FILTERS (NF),
        .KERNEL_WIDTH(KW),
        .WEIGHT_WIDTH(WW),
        .POOLED_WIDTH(PW),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .filter_bank(filter_bank),
        .conv_filter(conv_filter),
        .conv_reset (conv_reset),
        .relu_reset (relu_reset),
        .pool_reset (pool_reset),
        .conv_done  (conv_done),
        .relu_done  (relu_done),
        .pool_done  (pool_done),
        .pooled_in  (pooled_in),
        .out_maps   (out_maps),
        .channel_idx(channel_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage models: done rises LAT cycles after their reset drops.
    always @(posedge clk) begin
        c_cnt <= conv_reset ? 4'd0 : ((c_cnt == 4'd15) ? c_cnt : c_cnt + 4'd1);
        r_cnt <= relu_reset ? 4'd0 : ((r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1);
        p_cnt <= pool_reset ? 4'd0 : ((p_cnt == 4'd15) ? p_cnt : p_cnt + 4'd1);
    end
    assign conv_done = conv_force | (c_cnt >= 4'(LAT));
    assign relu_done = !relu_stall && (r_cnt >= 4'(LAT));
    assign pool_done = (p_cnt >= 4'(LAT));

    // Observer: records per-run events and presents a per-channel pooled map.
    always @(negedge clk) begin
        if (busy && !busy_p) begin
            conv_seen     = 0;
            pool_seen     = 0;
            conv_only_len = 0;
        end
        if (conv_p && !conv_reset) begin
            if (conv_seen < 2) begin
                filt_seen[conv_seen]  = conv_filter;
                chidx_seen[conv_seen] = channel_idx;
            end
            conv_seen++;
        end
        if (pool_p && !pool_reset) begin
            pooled_in = (pool_seen == 0) ? PAT0 : PAT1;
            pool_seen++;
        end
        if (!conv_reset && relu_reset) conv_only_len++;
        if (done) done_count++;
        busy_p = busy;
        conv_p = conv_reset;
        pool_p = pool_reset;
    end

    task automatic chk(input string tag, input cw_t got, input cw_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_layer(input string tag, input bit hold, input int exp_lat);
        int n;
        int dc0;
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk({tag, "_busy"}, cw_t'(busy), cw_t'(1));
        chk({tag, "_err_clr"}, cw_t'(error), cw_t'(0));
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, cw_t'(n), cw_t'(exp_lat));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_idle_after"}, cw_t'(busy), cw_t'(0));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, cw_t'(done_count - dc0), cw_t'(1));
        chk({tag, "_still_idle"}, cw_t'(busy), cw_t'(0));
    endtask

    task automatic check_result(input string tag, input int exp_conv_len);
        chk({tag, "_maps"}, cw_t'(out_maps), cw_t'({PAT1, PAT0}));
        chk({tag, "_filt0"}, cw_t'(filt_seen[0]), cw_t'(F0));
        chk({tag, "_filt1"}, cw_t'(filt_seen[1]), cw_t'(F1));
        chk({tag, "_ch0"}, cw_t'(chidx_seen[0]), cw_t'(0));
        chk({tag, "_ch1"}, cw_t'(chidx_seen[1]), cw_t'(1));
        chk({tag, "_ch_hold"}, cw_t'(channel_idx), cw_t'(NF - 1));
        chk({tag, "_conv_len"}, cw_t'(conv_only_len), cw_t'(exp_conv_len));
        chk({tag, "_error"}, cw_t'(error), cw_t'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, cw_t'(busy), cw_t'(0));
        chk({tag, "_done"}, cw_t'(done), cw_t'(0));
        chk({tag, "_error"}, cw_t'(error), cw_t'(0));
        chk({tag, "_ch"}, cw_t'(channel_idx), cw_t'(0));
        chk({tag, "_maps"}, cw_t'(out_maps), cw_t'(0));
        chk({tag, "_filter"}, cw_t'(conv_filter), cw_t'(0));
        chk({tag, "_resets"}, cw_t'({conv_reset, relu_reset, pool_reset}), cw_t'(3'b111));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        n_chk       = 0;
        n_pass      = 0;
        start       = 1'b0;
        conv_force  = 1'b0;
        relu_stall  = 1'b0;
        filter_bank = {F1, F0};
        reset       = 1'b1;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        run_layer("run1", 1'b0, EXP_LAT);
        check_result("run1", NF * (LAT + 1));

        // start held high for the whole run, including the FINISH cycle
        run_layer("hold", 1'b1, EXP_LAT);
        check_result("hold", NF * (LAT + 1));

        // relu never finishes on channel 0
        relu_stall = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (relu_reset && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_latency", cw_t'(n), cw_t'(TO));
        chk("stall_error", cw_t'(error), cw_t'(1));
        chk("stall_resets", cw_t'({conv_reset, relu_reset, pool_reset}), cw_t'(3'b111));
        chk("stall_maps", cw_t'(out_maps), cw_t'(0));
        @(posedge clk);
        #1;
        chk("stall_idle", cw_t'(busy), cw_t'(0));
        chk("stall_err_sticky", cw_t'(error), cw_t'(1));
        relu_stall = 1'b0;

        // conv done level already high when the run starts
        conv_force = 1'b1;
        run_layer("stale", 1'b0, EXP_LAT_STALE);
        check_result("stale", NF * 2);
        conv_force = 1'b0;

        // async reset in the middle of channel 1 pooling
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(channel_idx == CH_W'(1) && !pool_reset) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_pool_reached", cw_t'(pool_reset), cw_t'(0));
        chk("mid_pool_slice0", cw_t'(out_maps), cw_t'(PAT0));
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        chk("async_held_maps", cw_t'(out_maps), cw_t'(0));
        @(negedge clk);
        reset = 1'b0;
        run_layer("after_rst", 1'b0, EXP_LAT);
        check_result("after_rst", NF * (LAT + 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
